hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage RV32 core (IF, ID, EX, MEM, WB).
- Generates the stall, enable and flush controls for the IF, ID and EX pipe registers, plus the EX-operand forwarding selects.
- Handles three cases: load-use bubbles, data-memory wait freezes, and multi-cycle squash after a taken branch/jump, which the synchronous imem requires.
- Sits beside the datapath and drives StallIF, StallID, EnableID and FlushE.

---
 rtl/rv32_pkg.sv | 42 ++++
 rtl/hazard_fwd_sel.sv | 31 +++
 rtl/hazard_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared definitions for the RV32 pipeline hazard sequencer.
//   - Forwarding select encodings used by the EX operand muxes.
//   - Hazard sequencer state encoding.
//   - Packed bundle of the pipe-fence control signals.
//   - fwd_hit(): register-match helper shared by forwarding and load-use detection.
package rv32_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value from ID/EX
  localparam logic [1:0] FWD_WB  = 2'b01;  // result in the WB stage
  localparam logic [1:0] FWD_MEM = 2'b10;  // result in the MEM stage

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_MEM_WAIT = 2'b01,
    HZ_REDIRECT = 2'b10
  } hz_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic enable_id;
    logic flush_id;
    logic flush_e;
    logic stall_m;
  } hz_ctrl_t;

  // Field order: stall_if, stall_id, enable_id, flush_id, flush_e, stall_m
  localparam hz_ctrl_t HZ_CTRL_IDLE   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam hz_ctrl_t HZ_CTRL_FREEZE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam hz_ctrl_t HZ_CTRL_FLUSH  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam hz_ctrl_t HZ_CTRL_BUBBLE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam hz_ctrl_t HZ_CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  // True when a writing stage targets rs; x0 never matches since it is hardwired.
  function automatic logic fwd_hit(input logic       wr_en,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs);
    return wr_en && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: combinational forwarding select for one EX operand.
// Ports:
//   rsn_ex_i       EX-stage source register of this operand
//   rdn_mem_i      MEM-stage destination register
//   regwrite_mem_i MEM-stage write enable
//   rdn_wb_i       WB-stage destination register
//   regwrite_wb_i  WB-stage write enable
//   fwd_o          operand select (FWD_MEM / FWD_WB / FWD_RF)
module hazard_fwd_sel (
  input  logic [4:0] rsn_ex_i,
  input  logic [4:0] rdn_mem_i,
  input  logic       regwrite_mem_i,
  input  logic [4:0] rdn_wb_i,
  input  logic       regwrite_wb_i,
  output logic [1:0] fwd_o
);
  import rv32_pkg::*;

  // MEM holds the younger result, so it wins over WB
  always_comb begin
    fwd_o = FWD_RF;
    if (fwd_hit(regwrite_mem_i, rdn_mem_i, rsn_ex_i)) begin
      fwd_o = FWD_MEM;
    end else if (fwd_hit(regwrite_wb_i, rdn_wb_i, rsn_ex_i)) begin
      fwd_o = FWD_WB;
    end else begin
      fwd_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage RV32 core.
// Produces the IF/ID/EX fence stall/enable/flush controls and the EX operand
// forwarding selects. Handles load-use bubbles, data-memory wait freezes and
// the multi-cycle squash after a taken redirect (synchronous imem latency).
// All controls are combinational from the current state and inputs.
// Ports:
//   clk, rst (async, active-low)
//   rs1n_ID/rs2n_ID/uses_rs1_ID/uses_rs2_ID     ID-stage sources
//   rs1n_EX/rs2n_EX/rdn_EX/MemToReg_EX          EX-stage registers, load flag
//   rdn_MEM/RegWrite_MEM, rdn_WB/RegWrite_WB    writing stages
//   redirect_EX, dmem_busy                      redirect and memory wait
//   StallIF/StallID/EnableID/FlushID/FlushE/StallM  fence controls
//   FwdA_EX/FwdB_EX                             forwarding selects
//   stall_cnt/flush_cnt                         performance counters
// Build option: define HAZARD_PERF_CNT_EN to build the performance counters;
// otherwise both counter ports are tied to zero.
module hazard_ctrl #(
  parameter int REDIRECT_BUBBLES = 2,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1n_ID,
  input  logic [4:0]       rs2n_ID,
  input  logic             uses_rs1_ID,
  input  logic             uses_rs2_ID,
  input  logic [4:0]       rs1n_EX,
  input  logic [4:0]       rs2n_EX,
  input  logic [4:0]       rdn_EX,
  input  logic             MemToReg_EX,
  input  logic [4:0]       rdn_MEM,
  input  logic             RegWrite_MEM,
  input  logic [4:0]       rdn_WB,
  input  logic             RegWrite_WB,
  input  logic             redirect_EX,
  input  logic             dmem_busy,
  output logic             StallIF,
  output logic             StallID,
  output logic             EnableID,
  output logic             FlushID,
  output logic             FlushE,
  output logic             StallM,
  output logic [1:0]       FwdA_EX,
  output logic [1:0]       FwdB_EX,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import rv32_pkg::*;

  // Flush cycles remaining after the redirect cycle itself
  localparam logic [2:0] BUBBLE_LOAD   = 3'(REDIRECT_BUBBLES - 1);
  localparam logic       SINGLE_BUBBLE = (REDIRECT_BUBBLES == 1);

  hz_state_e  state_q, state_d;
  logic [2:0] bubble_q, bubble_d;
  logic       pend_redir_q, pend_redir_d;
  logic       lu_s;
  hz_ctrl_t   ctrl_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  hazard_fwd_sel u_fwd_a (
    .rsn_ex_i       (rs1n_EX),
    .rdn_mem_i      (rdn_MEM),
    .regwrite_mem_i (RegWrite_MEM),
    .rdn_wb_i       (rdn_WB),
    .regwrite_wb_i  (RegWrite_WB),
    .fwd_o          (fwd_a_s)
  );

  hazard_fwd_sel u_fwd_b (
    .rsn_ex_i       (rs2n_EX),
    .rdn_mem_i      (rdn_MEM),
    .regwrite_mem_i (RegWrite_MEM),
    .rdn_wb_i       (rdn_WB),
    .regwrite_wb_i  (RegWrite_WB),
    .fwd_o          (fwd_b_s)
  );

  // A load in EX whose destination is read by the ID instruction
  assign lu_s = fwd_hit(MemToReg_EX && uses_rs1_ID, rdn_EX, rs1n_ID) ||
                fwd_hit(MemToReg_EX && uses_rs2_ID, rdn_EX, rs2n_ID);

  // State register: sequencer state, bubble counter, deferred redirect flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HZ_RUN;
      bubble_q     <= 3'd0;
      pend_redir_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bubble_q     <= bubble_d;
      pend_redir_q <= pend_redir_d;
    end
  end

  // Next-state logic: memory wait outranks redirect, which outranks load-use
  always_comb begin
    state_d      = state_q;
    bubble_d     = bubble_q;
    pend_redir_d = pend_redir_q;
    case (state_q)
      HZ_RUN: begin
        if (dmem_busy) begin
          // A redirect seen while freezing is replayed when the wait ends
          state_d      = HZ_MEM_WAIT;
          pend_redir_d = redirect_EX;
        end else if (redirect_EX) begin
          bubble_d     = BUBBLE_LOAD;
          state_d      = SINGLE_BUBBLE ? HZ_RUN : HZ_REDIRECT;
          pend_redir_d = 1'b0;
        end else begin
          state_d      = HZ_RUN;
          pend_redir_d = 1'b0;
        end
      end
      HZ_MEM_WAIT: begin
        if (dmem_busy) begin
          state_d = HZ_MEM_WAIT;
        end else if (pend_redir_q || redirect_EX) begin
          bubble_d     = BUBBLE_LOAD;
          state_d      = SINGLE_BUBBLE ? HZ_RUN : HZ_REDIRECT;
          pend_redir_d = 1'b0;
        end else begin
          state_d      = HZ_RUN;
          pend_redir_d = 1'b0;
        end
      end
      HZ_REDIRECT: begin
        if (dmem_busy) begin
          state_d = HZ_REDIRECT;
        end else if (bubble_q <= 3'd1) begin
          bubble_d = 3'd0;
          state_d  = HZ_RUN;
        end else begin
          bubble_d = bubble_q - 3'd1;
        end
      end
      default: begin
        state_d      = HZ_RUN;
        bubble_d     = 3'd0;
        pend_redir_d = 1'b0;
      end
    endcase
  end

  // Output logic: reset forces the flush pattern without waiting for a clock
  always_comb begin
    ctrl_s = HZ_CTRL_IDLE;
    if (!rst) begin
      ctrl_s = HZ_CTRL_RESET;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (dmem_busy) begin
            ctrl_s = HZ_CTRL_FREEZE;
          end else if (redirect_EX) begin
            ctrl_s = HZ_CTRL_FLUSH;  // redirect squashes the load-use consumer too
          end else if (lu_s) begin
            ctrl_s = HZ_CTRL_BUBBLE;
          end else begin
            ctrl_s = HZ_CTRL_IDLE;
          end
        end
        HZ_MEM_WAIT: begin
          if (dmem_busy) begin
            ctrl_s = HZ_CTRL_FREEZE;
          end else if (pend_redir_q || redirect_EX) begin
            ctrl_s = HZ_CTRL_FLUSH;
          end else if (lu_s) begin
            ctrl_s = HZ_CTRL_BUBBLE;
          end else begin
            ctrl_s = HZ_CTRL_IDLE;
          end
        end
        HZ_REDIRECT: begin
          // EX holds a flushed bubble, so redirect_EX and load-use are ignored
          if (dmem_busy) begin
            ctrl_s = HZ_CTRL_FREEZE;
          end else begin
            ctrl_s = HZ_CTRL_FLUSH;
          end
        end
        default: begin
          ctrl_s = HZ_CTRL_RESET;
        end
      endcase
    end
  end

  assign StallIF  = ctrl_s.stall_if;
  assign StallID  = ctrl_s.stall_id;
  assign EnableID = ctrl_s.enable_id;
  assign FlushID  = ctrl_s.flush_id;
  assign FlushE   = ctrl_s.flush_e;
  assign StallM   = ctrl_s.stall_m;
  assign FwdA_EX  = rst ? fwd_a_s : FWD_RF;
  assign FwdB_EX  = rst ? fwd_b_s : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Performance counters: wrap naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (ctrl_s.stall_if) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (ctrl_s.flush_id) begin
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed literal checks plus randomized stimulus checked
// every cycle against a behavioural model of the hazard sequencer.
// Define HAZARD_PERF_CNT_EN to check the performance counters.
module tb_hazard_ctrl;

  localparam int RB = 2;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1n_ID, rs2n_ID, rs1n_EX, rs2n_EX, rdn_EX, rdn_MEM, rdn_WB;
  logic        uses_rs1_ID, uses_rs2_ID, MemToReg_EX, RegWrite_MEM, RegWrite_WB;
  logic        redirect_EX, dmem_busy;
  logic        StallIF, StallID, EnableID, FlushID, FlushE, StallM;
  logic [1:0]  FwdA_EX, FwdB_EX;
  logic [31:0] stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl #(.REDIRECT_BUBBLES(RB), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1n_ID(rs1n_ID), .rs2n_ID(rs2n_ID),
    .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
    .rs1n_EX(rs1n_EX), .rs2n_EX(rs2n_EX), .rdn_EX(rdn_EX),
    .MemToReg_EX(MemToReg_EX),
    .rdn_MEM(rdn_MEM), .RegWrite_MEM(RegWrite_MEM),
    .rdn_WB(rdn_WB), .RegWrite_WB(RegWrite_WB),
    .redirect_EX(redirect_EX), .dmem_busy(dmem_busy),
    .StallIF(StallIF), .StallID(StallID), .EnableID(EnableID),
    .FlushID(FlushID), .FlushE(FlushE), .StallM(StallM),
    .FwdA_EX(FwdA_EX), .FwdB_EX(FwdB_EX),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control pattern: StallIF, StallID, EnableID, FlushID, FlushE, StallM
  typedef struct packed {
    logic sif; logic sid; logic en; logic fid; logic fe; logic sm;
  } exp_t;

  localparam exp_t E_RESET  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam exp_t E_IDLE   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_FREEZE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam exp_t E_FLUSH  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam exp_t E_BUBBLE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  // Behavioural model state
  int          owed;     // flush cycles still owed after the current one
  bit          waiting;  // inside a memory wait entered from normal flow
  bit          pend;     // redirect captured on entry to that wait
  logic [31:0] m_stall, m_flush;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (RegWrite_MEM && rdn_MEM != 5'd0 && rdn_MEM == rs) return 2'b10;
    if (RegWrite_WB && rdn_WB != 5'd0 && rdn_WB == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expect_ctl();
    bit lu;
    lu = MemToReg_EX && rdn_EX != 5'd0 &&
         ((uses_rs1_ID && rs1n_ID == rdn_EX) || (uses_rs2_ID && rs2n_ID == rdn_EX));
    if (!rst) return E_RESET;
    if (dmem_busy) return E_FREEZE;
    if (owed > 0) return E_FLUSH;
    if (redirect_EX || (waiting && pend)) return E_FLUSH;
    if (lu) return E_BUBBLE;
    return E_IDLE;
  endfunction

  // Compare process: mid-cycle check, then advance the model past the next edge
  initial begin
    exp_t e;
    bit   redir;
    owed = 0; waiting = 1'b0; pend = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
    forever begin
      @(negedge clk);
      e = expect_ctl();
      chk("cmp_StallIF",  32'(StallIF),  32'(e.sif));
      chk("cmp_StallID",  32'(StallID),  32'(e.sid));
      chk("cmp_EnableID", 32'(EnableID), 32'(e.en));
      chk("cmp_FlushID",  32'(FlushID),  32'(e.fid));
      chk("cmp_FlushE",   32'(FlushE),   32'(e.fe));
      chk("cmp_StallM",   32'(StallM),   32'(e.sm));
      chk("cmp_FwdA", 32'(FwdA_EX), 32'(rst ? fwd_exp(rs1n_EX) : 2'b00));
      chk("cmp_FwdB", 32'(FwdB_EX), 32'(rst ? fwd_exp(rs2n_EX) : 2'b00));
`ifdef HAZARD_PERF_CNT_EN
      chk("cmp_stall_cnt", stall_cnt, rst ? m_stall : 32'd0);
      chk("cmp_flush_cnt", flush_cnt, rst ? m_flush : 32'd0);
`else
      chk("cmp_stall_cnt", stall_cnt, 32'd0);
      chk("cmp_flush_cnt", flush_cnt, 32'd0);
`endif
      if (!rst) begin
        owed = 0; waiting = 1'b0; pend = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
      end else begin
        if (e.sif) m_stall = m_stall + 32'd1;
        if (e.fid) m_flush = m_flush + 32'd1;
        if (dmem_busy) begin
          if (owed == 0 && !waiting) begin
            waiting = 1'b1;
            pend    = redirect_EX;
          end
        end else if (owed > 0) begin
          owed = owed - 1;
        end else begin
          redir   = redirect_EX || (waiting && pend);
          waiting = 1'b0;
          pend    = 1'b0;
          if (redir) owed = RB - 1;
        end
      end
    end
  end

  task automatic clear_inputs();
    rs1n_ID = 5'd0; rs2n_ID = 5'd0; rs1n_EX = 5'd0; rs2n_EX = 5'd0;
    rdn_EX = 5'd0; rdn_MEM = 5'd0; rdn_WB = 5'd0;
    uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0; MemToReg_EX = 1'b0;
    RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0;
    redirect_EX = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    rs1n_ID      = 5'($urandom_range(0, 3));
    rs2n_ID      = 5'($urandom_range(0, 3));
    rs1n_EX      = 5'($urandom_range(0, 3));
    rs2n_EX      = 5'($urandom_range(0, 3));
    rdn_EX       = 5'($urandom_range(0, 3));
    rdn_MEM      = 5'($urandom_range(0, 3));
    rdn_WB       = 5'($urandom_range(0, 3));
    uses_rs1_ID  = ($urandom_range(0, 1) == 1);
    uses_rs2_ID  = ($urandom_range(0, 1) == 1);
    MemToReg_EX  = ($urandom_range(0, 1) == 1);
    RegWrite_MEM = ($urandom_range(0, 1) == 1);
    RegWrite_WB  = ($urandom_range(0, 1) == 1);
    redirect_EX  = ($urandom_range(0, 5) == 0);
    dmem_busy    = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    #2;
    chk("rst_StallIF",  32'(StallIF),  32'd0);
    chk("rst_StallID",  32'(StallID),  32'd0);
    chk("rst_EnableID", 32'(EnableID), 32'd0);
    chk("rst_FlushID",  32'(FlushID),  32'd1);
    chk("rst_FlushE",   32'(FlushE),   32'd1);
    chk("rst_StallM",   32'(StallM),   32'd0);
    step(); step();
    rst = 1'b1;
    step();

    // Load-use: lw x5 in EX, ID reads x5 -> single bubble
    MemToReg_EX = 1'b1; rdn_EX = 5'd5; uses_rs1_ID = 1'b1; rs1n_ID = 5'd5;
    #1;
    chk("lu_StallIF",  32'(StallIF),  32'd1);
    chk("lu_EnableID", 32'(EnableID), 32'd0);
    chk("lu_FlushE",   32'(FlushE),   32'd1);
    step();
    MemToReg_EX = 1'b0; rdn_EX = 5'd9; rdn_MEM = 5'd5; RegWrite_MEM = 1'b1;
    #1;
    chk("lu_next_StallIF",  32'(StallIF),  32'd0);
    chk("lu_next_EnableID", 32'(EnableID), 32'd1);
    chk("lu_next_FlushE",   32'(FlushE),   32'd0);

    // Forwarding: MEM beats WB, x0 never forwards
    RegWrite_MEM = 1'b1; rdn_MEM = 5'd3; RegWrite_WB = 1'b1; rdn_WB = 5'd3; rs1n_EX = 5'd3;
    #1;
    chk("fwd_mem_prio", 32'(FwdA_EX), 32'd2);
    rdn_MEM = 5'd0; rdn_WB = 5'd0;
    #1;
    chk("fwd_x0", 32'(FwdA_EX), 32'd0);
    rdn_WB = 5'd3; rs2n_EX = 5'd3;
    #1;
    chk("fwd_wbA", 32'(FwdA_EX), 32'd1);
    chk("fwd_wbB", 32'(FwdB_EX), 32'd1);
    clear_inputs();
    step();

    // Redirect pulse -> two flush cycles then idle
    redirect_EX = 1'b1;
    #1;
    chk("redir1_FlushID", 32'(FlushID), 32'd1);
    chk("redir1_FlushE",  32'(FlushE),  32'd1);
    step();
    redirect_EX = 1'b0;
    #1;
    chk("redir2_FlushID", 32'(FlushID), 32'd1);
    chk("redir2_FlushE",  32'(FlushE),  32'd1);
    step();
    chk("redir3_FlushID",  32'(FlushID),  32'd0);
    chk("redir3_EnableID", 32'(EnableID), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall", stall_cnt, 32'd1);
    chk("perf_flush", flush_cnt, 32'd2);
`else
    chk("perf_stall", stall_cnt, 32'd0);
    chk("perf_flush", flush_cnt, 32'd0);
`endif

    // Memory wait of 3 cycles with a redirect on the first
    dmem_busy = 1'b1; redirect_EX = 1'b1;
    #1;
    chk("busy1_StallM", 32'(StallM), 32'd1);
    chk("busy1_StallIF", 32'(StallIF), 32'd1);
    step();
    redirect_EX = 1'b0;
    chk("busy2_StallM", 32'(StallM), 32'd1);
    step();
    chk("busy3_StallM", 32'(StallM), 32'd1);
    step();
    dmem_busy = 1'b0;
    #1;
    chk("busy_fl1_StallM",  32'(StallM),  32'd0);
    chk("busy_fl1_FlushID", 32'(FlushID), 32'd1);
    step();
    chk("busy_fl2_FlushID", 32'(FlushID), 32'd1);
    step();
    chk("busy_end_FlushID",  32'(FlushID),  32'd0);
    chk("busy_end_EnableID", 32'(EnableID), 32'd1);

    // Asynchronous reset in the middle of a redirect window
    redirect_EX = 1'b1;
    step();
    redirect_EX = 1'b0; RegWrite_MEM = 1'b1; rdn_MEM = 5'd7; rs1n_EX = 5'd7;
    #1;
    chk("midredir_EnableID", 32'(EnableID), 32'd1);
    chk("midredir_FwdA",     32'(FwdA_EX),  32'd2);
    rst = 1'b0;
    #1;
    chk("arst_EnableID", 32'(EnableID), 32'd0);
    chk("arst_FlushID",  32'(FlushID),  32'd1);
    chk("arst_StallIF",  32'(StallIF),  32'd0);
    chk("arst_FwdA",     32'(FwdA_EX),  32'd0);
    chk("arst_cnt",      stall_cnt | flush_cnt, 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("arst_rel_FlushID",  32'(FlushID),  32'd0);
    chk("arst_rel_EnableID", 32'(EnableID), 32'd1);

    // Randomized phase with occasional one-cycle resets
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_inputs();
      if (!rst) begin
        rst = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
      end
    end
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
